// File: rtl/xeng_window_sched_pkg.sv
// Shared definitions for the X-engine window scheduler: FSM state
// encoding, default parameter values and a width helper.
package xeng_window_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  localparam int DEF_SERIAL_ACC_LEN_BITS = 7;
  localparam int DEF_N_ANTS              = 8;
  localparam int DEF_N_TAPS              = 5;
  localparam int DEF_PIPE_LATENCY        = 16;

  // Bits needed to index n items; a single item still gets a 1-bit field.
  function automatic int sched_log2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xeng_window_sched_pulse_delay.sv
// Fixed-depth register delay line. The MSB of each word is its valid
// flag; busy reports whether any stage currently holds a valid word.
// clr empties the whole line in one cycle.
module xeng_window_sched_pulse_delay #(
  parameter int WIDTH = 4,
  parameter int DELAY = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  logic [WIDTH-1:0] pipe_q [DELAY];

  // Shift register; reset and flush both empty every stage.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Any valid flag still in flight, including the output stage.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DELAY; i++) busy = busy | pipe_q[i][WIDTH-1];
  end

  assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/xeng_window_sched.sv
// X-engine baseline_tap chain sequencer. Aligns the frame counter to the
// input sync, issues the first-tap reset pulse, tracks antenna/accumulation
// slots and announces the per-tap result burst leaving the chain end.
// Optional feature macro: XENG_SCHED_STATS_EN adds win_cnt / err_cnt.
//
// state  | meaning
// IDLE   | stopped, waiting for en
// ARM    | enabled, waiting for the first sync_in
// RUN    | frame counter running, window ends fed into the delay line
// DRAIN  | counters frozen, in-flight result bursts finishing
module xeng_window_sched
  import xeng_window_sched_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = DEF_SERIAL_ACC_LEN_BITS,
  parameter int N_ANTS              = DEF_N_ANTS,
  parameter int N_TAPS              = DEF_N_TAPS,
  parameter int PIPE_LATENCY        = DEF_PIPE_LATENCY,
  localparam int ANT_W              = sched_log2(N_ANTS),
  localparam int TAP_W              = sched_log2(N_TAPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           sync_in,
  output logic                           tap_rst,
  output logic [ANT_W-1:0]               ant_slot,
  output logic [SERIAL_ACC_LEN_BITS-1:0] acc_slot,
  output logic                           running,
  output logic                           out_valid,
  output logic [TAP_W-1:0]               out_tap,
  output logic [ANT_W-1:0]               out_ant,
  output logic                           sync_err
`ifdef XENG_SCHED_STATS_EN
  ,
  output logic [31:0]                    win_cnt,
  output logic [15:0]                    err_cnt
`endif
);

  localparam int WIN_LEN   = 1 << SERIAL_ACC_LEN_BITS;
  localparam int FRAME_LEN = N_ANTS * WIN_LEN;
  localparam int FC_W      = SERIAL_ACC_LEN_BITS + ANT_W;

  // Unload bursts must fit inside one window or they would overlap.
  if (N_TAPS < 1 || N_TAPS > WIN_LEN) begin : g_bad_taps
    $error("xeng_window_sched: N_TAPS must be in 1..2^SERIAL_ACC_LEN_BITS");
  end
  if (PIPE_LATENCY < 1) begin : g_bad_latency
    $error("xeng_window_sched: PIPE_LATENCY must be >= 1");
  end
  if (N_ANTS < 2 || SERIAL_ACC_LEN_BITS < 1) begin : g_bad_frame
    $error("xeng_window_sched: need N_ANTS >= 2 and SERIAL_ACC_LEN_BITS >= 1");
  end

  sched_state_e     state_q, state_d;
  logic [FC_W-1:0]  frame_ctr;
  logic             frame_last;
  logic             stop_req;
  logic             start_run;
  logic             mis_sync;
  logic             win_end;

  logic [ANT_W:0]   dly_din, dly_dout;
  logic             dly_busy;
  logic             dly_pulse;
  logic [ANT_W-1:0] dly_ant;

  logic [TAP_W-1:0] unl_left;
  logic [TAP_W-1:0] unl_tap;
  logic [ANT_W-1:0] unl_ant;

  assign frame_last = (frame_ctr == FC_W'(FRAME_LEN - 1));
  assign ant_slot   = frame_ctr[FC_W-1:SERIAL_ACC_LEN_BITS];
  assign acc_slot   = frame_ctr[SERIAL_ACC_LEN_BITS-1:0];
  assign running    = (state_q == ST_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the single-cycle control strobes derived from it.
  // A sync landing on the last frame slot is the expected one and is ignored.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    mis_sync  = 1'b0;
    win_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (sync_in) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        win_end = (acc_slot == '1);
        if (sync_in && !frame_last) begin
          mis_sync = 1'b1;
        end else if (frame_last && (stop_req || !en)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!dly_busy && (unl_left == '0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame counter, tap reset pulse, sticky error and the latched stop request.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ctr <= '0;
      tap_rst   <= 1'b0;
      sync_err  <= 1'b0;
      stop_req  <= 1'b0;
    end else begin
      tap_rst <= start_run | mis_sync;
      if (mis_sync) sync_err <= 1'b1;
      if (start_run || mis_sync || (running && frame_last)) frame_ctr <= '0;
      else if (running)                                     frame_ctr <= frame_ctr + FC_W'(1);
      if (!running)  stop_req <= 1'b0;
      else if (!en)  stop_req <= 1'b1;
    end
  end

  assign dly_din = {win_end, ant_slot};

  xeng_window_sched_pulse_delay #(
    .WIDTH (ANT_W + 1),
    .DELAY (PIPE_LATENCY)
  ) u_pulse_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (mis_sync),
    .din  (dly_din),
    .dout (dly_dout),
    .busy (dly_busy)
  );

  assign dly_pulse = dly_dout[ANT_W];
  assign dly_ant   = dly_dout[ANT_W-1:0];

  // Unload counter: the delayed pulse emits tap 0 directly, this counts
  // down the remaining taps of the burst while holding its antenna slot.
  always_ff @(posedge clk) begin
    if (rst || mis_sync) begin
      unl_left <= '0;
      unl_tap  <= '0;
      unl_ant  <= '0;
    end else if (dly_pulse) begin
      unl_left <= TAP_W'(N_TAPS - 1);
      unl_tap  <= TAP_W'(1);
      unl_ant  <= dly_ant;
    end else if (unl_left != '0) begin
      unl_left <= unl_left - TAP_W'(1);
      unl_tap  <= unl_tap + TAP_W'(1);
    end
  end

  // Chain-output word qualifiers; zero whenever no word is leaving.
  always_comb begin
    out_valid = 1'b0;
    out_tap   = '0;
    out_ant   = '0;
    if (dly_pulse) begin
      out_valid = 1'b1;
      out_ant   = dly_ant;
    end else if (unl_left != '0) begin
      out_valid = 1'b1;
      out_tap   = unl_tap;
      out_ant   = unl_ant;
    end
  end

`ifdef XENG_SCHED_STATS_EN
  // Window count wraps; misaligned-sync count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (win_end) win_cnt <= win_cnt + 32'd1;
      if (mis_sync && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xeng_window_sched.sv
// Bench for xeng_window_sched (default parameters). Reference model keeps
// the scheduler mode, the cycle at which frame slot 0 last occurred and a
// queue of predicted result bursts; everything else is plain arithmetic.
module tb_xeng_window_sched;

  localparam int W  = 128;
  localparam int NA = 8;
  localparam int P  = NA * W;
  localparam int NT = 5;
  localparam int L  = 16;

  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sync_in = 1'b0;
  logic       tap_rst;
  logic [2:0] ant_slot;
  logic [6:0] acc_slot;
  logic       running;
  logic       out_valid;
  logic [2:0] out_tap;
  logic [2:0] out_ant;
  logic       sync_err;
`ifdef XENG_SCHED_STATS_EN
  logic [31:0] win_cnt;
  logic [15:0] err_cnt;
`endif

  xeng_window_sched dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync_in   (sync_in),
    .tap_rst   (tap_rst),
    .ant_slot  (ant_slot),
    .acc_slot  (acc_slot),
    .running   (running),
    .out_valid (out_valid),
    .out_tap   (out_tap),
    .out_ant   (out_ant),
    .sync_err  (sync_err)
`ifdef XENG_SCHED_STATS_EN
    ,
    .win_cnt   (win_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int          kc = 0;
  int          m_mode = M_IDLE;
  int          m_anchor = 0;
  bit          m_taprst = 0;
  bit          m_err = 0;
  bit          m_stop = 0;
  int unsigned m_wins = 0;
  int          m_errs = 0;
  int          bq_u[$];
  int          bq_ant[$];

  function automatic int m_pos();
    return (kc - m_anchor) % P;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic model_update();
    int prev_mode, prev_pos;
    bit we, mis;
    kc++;
    prev_mode = m_mode;
    prev_pos  = (m_mode == M_RUN) ? ((kc - 1 - m_anchor) % P) : 0;
    m_taprst  = 0;
    while (bq_u.size() > 0 && bq_u[0] + NT - 1 < kc - 1) begin
      void'(bq_u.pop_front());
      void'(bq_ant.pop_front());
    end
    if (rst) begin
      m_mode = M_IDLE; m_err = 0; m_stop = 0; m_wins = 0; m_errs = 0;
      bq_u.delete(); bq_ant.delete();
    end else begin
      case (prev_mode)
        M_IDLE: if (en) m_mode = M_ARM;
        M_ARM: begin
          if (!en) m_mode = M_IDLE;
          else if (sync_in) begin
            m_mode = M_RUN; m_anchor = kc; m_taprst = 1;
          end
        end
        M_RUN: begin
          we  = (prev_pos % W) == W - 1;
          mis = sync_in && (prev_pos != P - 1);
          if (we) m_wins++;
          if (we && !mis) begin
            bq_u.push_back(kc - 1 + L);
            bq_ant.push_back(prev_pos / W);
          end
          if (!en) m_stop = 1;
          if (mis) begin
            m_anchor = kc; m_taprst = 1; m_err = 1;
            bq_u.delete(); bq_ant.delete();
            if (m_errs < 65535) m_errs++;
          end else if (prev_pos == P - 1 && m_stop) begin
            m_mode = M_DRAIN; m_stop = 0;
          end
        end
        default: if (bq_u.size() == 0) m_mode = M_IDLE;
      endcase
    end
  endtask

  // Predicted chain-output word for the current cycle.
  task automatic model_out(output bit v, output logic [2:0] tap, output logic [2:0] ant);
    v = 0; tap = 3'd0; ant = 3'd0;
    foreach (bq_u[i]) begin
      if (bq_u[i] <= kc && kc <= bq_u[i] + NT - 1) begin
        v = 1; tap = 3'(kc - bq_u[i]); ant = 3'(bq_ant[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  // Step until the model frame position equals target; ok=0 on timeout.
  task automatic wait_pos(input int target, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (m_mode == M_RUN && m_pos() == target) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; sync_in = 0;
    step(); step();
    n_cmp++; if (running !== 1'b0)   begin n_err++; $display("FAIL reset_running got=%0b exp=0", running); end
    n_cmp++; if (tap_rst !== 1'b0)   begin n_err++; $display("FAIL reset_tap_rst got=%0b exp=0", tap_rst); end
    n_cmp++; if (sync_err !== 1'b0)  begin n_err++; $display("FAIL reset_sync_err got=%0b exp=0", sync_err); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_cmp++; if ({ant_slot, acc_slot} !== 10'd0) begin n_err++; $display("FAIL reset_slots got=%0d/%0d exp=0/0", ant_slot, acc_slot); end
    n_cmp++; if ({out_tap, out_ant} !== 6'd0) begin n_err++; $display("FAIL reset_out_fields got=%0d/%0d exp=0/0", out_tap, out_ant); end
`ifdef XENG_SCHED_STATS_EN
    n_cmp++; if ({win_cnt, err_cnt} !== 48'd0) begin n_err++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", win_cnt, err_cnt); end
`endif
    rst = 0;
    step();
  endtask

  task automatic test_start();
    en = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL arm_running k=%0d got=%0b exp=0", kc, running); end
    end
    sync_in = 1;
    step();
    sync_in = 0;
    n_cmp++; if (tap_rst !== 1'b1) begin n_err++; $display("FAIL start_tap_rst got=%0b exp=1", tap_rst); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running got=%0b exp=1", running); end
    n_cmp++; if ({ant_slot, acc_slot} !== 10'd0) begin n_err++; $display("FAIL start_frame_ctr got=%0d/%0d exp=0/0", ant_slot, acc_slot); end
    step();
    n_cmp++; if (tap_rst !== 1'b0) begin n_err++; $display("FAIL start_tap_rst_low got=%0b exp=0", tap_rst); end
    n_cmp++; if (acc_slot !== 7'd1) begin n_err++; $display("FAIL start_acc_slot got=%0d exp=1", acc_slot); end
  endtask

  task automatic test_free_run();
    int t0, first_v, second_v;
    bit ev; logic [2:0] et, ea;
    t0 = m_anchor; first_v = -1; second_v = -1;
    while (kc < t0 + 2 * W + L + NT + 4) begin
      step();
      model_out(ev, et, ea);
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL free_valid k=%0d got=%0b exp=%0b", kc - t0, out_valid, ev); end
      if (ev) begin
        n_cmp++; if ({out_tap, out_ant} !== {et, ea}) begin n_err++; $display("FAIL free_tap_ant k=%0d got=%0d/%0d exp=%0d/%0d", kc - t0, out_tap, out_ant, et, ea); end
      end
      if (out_valid === 1'b1 && out_tap === 3'd0) begin
        if (first_v < 0) first_v = kc - t0;
        else if (second_v < 0) second_v = kc - t0;
      end
    end
    n_cmp++; if (first_v !== W - 1 + L) begin n_err++; $display("FAIL first_burst_time got=%0d exp=%0d", first_v, W - 1 + L); end
    n_cmp++; if (second_v !== 2 * W - 1 + L) begin n_err++; $display("FAIL second_burst_time got=%0d exp=%0d", second_v, 2 * W - 1 + L); end
  endtask

  task automatic test_aligned_sync();
    bit ok;
    for (int f = 0; f < 2; f++) begin
      wait_pos(P - 1, 2 * P, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL aligned_wait timeout got=0 exp=1"); end
      sync_in = 1;
      step();
      sync_in = 0;
      n_cmp++; if (tap_rst !== 1'b0) begin n_err++; $display("FAIL aligned_tap_rst got=%0b exp=0", tap_rst); end
      n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL aligned_sync_err got=%0b exp=0", sync_err); end
      n_cmp++; if ({ant_slot, acc_slot} !== 10'd0) begin n_err++; $display("FAIL aligned_wrap got=%0d/%0d exp=0/0", ant_slot, acc_slot); end
      step();
    end
  endtask

  task automatic test_misaligned();
    bit ok, ev; logic [2:0] et, ea;
    wait_pos(300, 2 * P, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mis_wait timeout got=0 exp=1"); end
    sync_in = 1;
    step();
    sync_in = 0;
    n_cmp++; if (tap_rst !== 1'b1) begin n_err++; $display("FAIL mis_tap_rst got=%0b exp=1", tap_rst); end
    n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL mis_sync_err got=%0b exp=1", sync_err); end
    n_cmp++; if ({ant_slot, acc_slot} !== 10'd0) begin n_err++; $display("FAIL mis_frame_ctr got=%0d/%0d exp=0/0", ant_slot, acc_slot); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_out_valid got=%0b exp=0", out_valid); end
`ifdef XENG_SCHED_STATS_EN
    n_cmp++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL mis_err_cnt got=%0d exp=1", err_cnt); end
`endif
    // Second misalignment while a window-end pulse is still in the delay line.
    wait_pos(262, 2 * P, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mis2_wait timeout got=0 exp=1"); end
    sync_in = 1;
    step();
    sync_in = 0;
    for (int i = 0; i < 300; i++) begin
      model_out(ev, et, ea);
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL mis2_valid pos=%0d got=%0b exp=%0b", m_pos(), out_valid, ev); end
      step();
    end
`ifdef XENG_SCHED_STATS_EN
    n_cmp++; if (err_cnt !== 16'd2) begin n_err++; $display("FAIL mis2_err_cnt got=%0d exp=2", err_cnt); end
`endif
  endtask

  task automatic test_drain();
    bit ok, ev, saw7; logic [2:0] et, ea;
    int idle_cnt;
    wait_pos(500, 2 * P, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL drain_wait timeout got=0 exp=1"); end
    en = 0; idle_cnt = 0; saw7 = 0;
    for (int i = 0; i < 4000 && idle_cnt < 5; i++) begin
      step();
      model_out(ev, et, ea);
      n_cmp++; if (running !== (m_mode == M_RUN)) begin n_err++; $display("FAIL drain_running k=%0d got=%0b exp=%0b", kc, running, m_mode == M_RUN); end
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL drain_valid k=%0d got=%0b exp=%0b", kc, out_valid, ev); end
      if (ev) begin
        n_cmp++; if ({out_tap, out_ant} !== {et, ea}) begin n_err++; $display("FAIL drain_tap_ant k=%0d got=%0d/%0d exp=%0d/%0d", kc, out_tap, out_ant, et, ea); end
        if (m_mode == M_DRAIN && ea == 3'd7 && et == 3'd4) saw7 = 1;
      end
      if (m_mode == M_IDLE) idle_cnt++;
    end
    n_cmp++; if (idle_cnt < 5) begin n_err++; $display("FAIL drain_to_idle timeout got=%0d exp=5", idle_cnt); end
    n_cmp++; if (!saw7) begin n_err++; $display("FAIL drain_last_burst got=0 exp=1"); end
  endtask

  task automatic test_rst_mid_burst();
    bit ok, ev; logic [2:0] et, ea;
    en = 1;
    step();
    sync_in = 1;
    step();
    sync_in = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      model_out(ev, et, ea);
      if (ev && et == 3'd2) begin ok = 1; break; end
      step();
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstb_wait timeout got=0 exp=1"); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstb_in_burst got=%0b exp=1", out_valid); end
    rst = 1;
    step();
    rst = 0;
    n_cmp++; if ({running, tap_rst, sync_err, out_valid} !== 4'd0) begin n_err++; $display("FAIL rstb_flags got=%b exp=0000", {running, tap_rst, sync_err, out_valid}); end
    n_cmp++; if ({ant_slot, acc_slot, out_tap, out_ant} !== 16'd0) begin n_err++; $display("FAIL rstb_fields got=%h exp=0", {ant_slot, acc_slot, out_tap, out_ant}); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rstb_needs_sync got=%0b exp=0", running); end
    end
    sync_in = 1;
    step();
    sync_in = 0;
    n_cmp++; if ({running, tap_rst} !== 2'b11) begin n_err++; $display("FAIL rstb_restart got=%b exp=11", {running, tap_rst}); end
  endtask

  task automatic test_random();
    bit ev; logic [2:0] et, ea;
    for (int i = 0; i < 8000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 299) == 0) en = !en;
      if (m_mode == M_RUN && m_pos() == P - 1) sync_in = ($urandom_range(0, 9) < 7);
      else sync_in = ($urandom_range(0, 699) == 0);
      step();
      model_out(ev, et, ea);
      n_cmp++; if (running !== (m_mode == M_RUN)) begin n_err++; $display("FAIL rnd_running k=%0d got=%0b exp=%0b", kc, running, m_mode == M_RUN); end
      n_cmp++; if (tap_rst !== m_taprst) begin n_err++; $display("FAIL rnd_tap_rst k=%0d got=%0b exp=%0b", kc, tap_rst, m_taprst); end
      n_cmp++; if (sync_err !== m_err) begin n_err++; $display("FAIL rnd_sync_err k=%0d got=%0b exp=%0b", kc, sync_err, m_err); end
      n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL rnd_valid k=%0d got=%0b exp=%0b", kc, out_valid, ev); end
      if (ev) begin
        n_cmp++; if ({out_tap, out_ant} !== {et, ea}) begin n_err++; $display("FAIL rnd_tap_ant k=%0d got=%0d/%0d exp=%0d/%0d", kc, out_tap, out_ant, et, ea); end
      end
      if (m_mode == M_RUN) begin
        n_cmp++; if ({ant_slot, acc_slot} !== 10'(m_pos())) begin n_err++; $display("FAIL rnd_slots k=%0d got=%0d/%0d exp=%0d", kc, ant_slot, acc_slot, m_pos()); end
      end
`ifdef XENG_SCHED_STATS_EN
      n_cmp++; if (win_cnt !== m_wins) begin n_err++; $display("FAIL rnd_win_cnt k=%0d got=%0d exp=%0d", kc, win_cnt, m_wins); end
      n_cmp++; if (err_cnt !== 16'(m_errs)) begin n_err++; $display("FAIL rnd_err_cnt k=%0d got=%0d exp=%0d", kc, err_cnt, m_errs); end
`endif
    end
    rst = 0; sync_in = 0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_free_run();
    test_aligned_sync();
    test_misaligned();
    test_drain();
    test_rst_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
